// File: rtl/gf2m_digit_mul.sv
`default_nettype none
// ==========================================================================
// gf2m_digit_mul : digit-serial GF(2^M) multiplier, result = a*b mod (x^M + POLY)
// Optional single-pass squaring path enabled by GF_MUL_SQR_EN.   Rev 1.0
// ==========================================================================
module gf2m_digit_mul #(
  parameter int           M    = 163,
  parameter int           D    = 8,
  parameter logic [M-1:0] POLY = 'hC9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef GF_MUL_SQR_EN
  input  logic         sq,
`endif
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] result
);

  localparam int N  = (M + D - 1) / D;
  localparam int NB = N * D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [M-1:0]  a_q;
  logic [NB-1:0] b_q;
  logic [M-1:0]  acc_q;
  logic [M-1:0]  acc_d;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic [M-1:0]  result_q;
  logic [D-1:0]  digit;
  logic          sq_sel;
  logic [M-1:0]  sq_res;

  // v * x mod f: one-bit shift with single fold of the carried-out bit
  function automatic logic [M-1:0] mul_x(input logic [M-1:0] v);
    return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY : '0);
  endfunction

  // v * x^D mod f: shift out the top D bits and fold them back as top*POLY
  function automatic logic [M-1:0] mul_xd(input logic [M-1:0] v);
    logic [D-1:0] top;
    logic [M-1:0] r;
    top = v[M-1 -: D];
    r   = {v[M-D-1:0], {D{1'b0}}};
    for (int i = 0; i < D; i++) begin
      if (top[i]) r = r ^ (POLY << i);
    end
    return r;
  endfunction

  // v * dg mod f as an XOR of the reduced shifted copies of v
  function automatic logic [M-1:0] mul_digit(input logic [M-1:0] v, input logic [D-1:0] dg);
    logic [M-1:0] r;
    logic [M-1:0] t;
    r = '0;
    t = v;
    for (int j = 0; j < D; j++) begin
      if (dg[j]) r = r ^ t;
      t = mul_x(t);
    end
    return r;
  endfunction

`ifdef GF_MUL_SQR_EN
  localparam int W2 = 2 * M - 1;

  // Squaring is linear: interleave zeros, then fold every bit above x^(M-1)
  function automatic logic [M-1:0] gf_sqr(input logic [M-1:0] v);
    logic [W2-1:0] p;
    logic [W2-1:0] fp;
    p  = '0;
    fp = W2'(POLY);
    for (int i = 0; i < M; i++) p[2*i] = v[i];
    for (int i = W2 - 1; i >= M; i--) begin
      if (p[i]) p = p ^ (fp << (i - M)) ^ (W2'(1) << i);
    end
    return p[M-1:0];
  endfunction

  assign sq_sel = sq;
  assign sq_res = gf_sqr(a);
`else
  assign sq_sel = 1'b0;
  assign sq_res = '0;
`endif

  assign digit = b_q[NB-1 -: D];
  assign acc_d = mul_xd(acc_q) ^ mul_digit(a_q, digit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (sq_sel) begin
              result_q <= sq_res;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              a_q     <= a;
              b_q     <= NB'(b);
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= MUL;
            end
          end
        end
        MUL: begin
          acc_q <= acc_d;
          b_q   <= b_q << D;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
            result_q <= acc_d;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
`default_nettype wire
